// File: rtl/intr_ctrl_pkg.sv
// rtl/intr_ctrl_pkg.sv - shared constants and FSM encoding for the interrupt controller
//
// Purpose: processor-level constants (PC width, vector table placement) and
// the controller state encoding, imported by intr_ctrl.
package intr_ctrl_pkg;

  localparam int              INTR_PC_W       = 10;
  localparam logic [9:0]      INTR_VEC_BASE   = 10'h3F0;
  localparam int              INTR_VEC_STRIDE = 4;
  localparam int              INTR_ID_W       = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/intr_ctrl_irq_edge_sync.sv
// rtl/intr_ctrl_irq_edge_sync.sv - per-line synchroniser and rising-edge detector
//
// Purpose: brings one asynchronous request line into the clk domain through
// two flops (s1, s2) and keeps one history flop (s3) for edge detection.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high reset (clears all three flops)
//   irq   in  asynchronous request line
//   rise  out one-cycle pulse on a synchronised 0->1 transition
module irq_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/intr_ctrl.sv
// rtl/intr_ctrl.sv - pending/mask/priority interrupt controller feeding the control unit
//
// Purpose: captures rising edges on the request lines as pending bits, masks
// them with the enable register, picks the lowest-index eligible line and
// issues a single-cycle s_interruption with the handler vector. No nesting:
// new entries wait until s_finish_interr returns the FSM to IDLE.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   irq               asynchronous request lines (rising edge significant)
//   ien_we, ien_in    enable-mask write strobe and new mask
//   ovr_clr           clears all overrun flags
//   s_finish_interr   handler completed (FNSH)
//   s_interruption    take interrupt this cycle
//   vector            handler address, valid while s_interruption is high
//   irq_id            line being or last serviced
//   in_service        high from entry until finish
//   pending           current pending bits
//   overrun           sticky: edge seen while the line was already pending
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int              N_IRQ      = 4,
  parameter int              PC_W       = INTR_PC_W,
  parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(INTR_VEC_BASE),
  parameter int              VEC_STRIDE = INTR_VEC_STRIDE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_IRQ-1:0]     irq,
  input  logic                 ien_we,
  input  logic [N_IRQ-1:0]     ien_in,
  input  logic                 ovr_clr,
  input  logic                 s_finish_interr,
  output logic                 s_interruption,
  output logic [PC_W-1:0]      vector,
  output logic [INTR_ID_W-1:0] irq_id,
  output logic                 in_service,
  output logic [N_IRQ-1:0]     pending,
  output logic [N_IRQ-1:0]     overrun
);

  state_t                 state;
  logic [N_IRQ-1:0]       ien;
  logic [N_IRQ-1:0]       rise;
  logic [N_IRQ-1:0]       elig;
  logic [N_IRQ-1:0]       clr;
  logic                   take;
  logic [INTR_ID_W-1:0]   winner;
  logic [PC_W-1:0]        vec_calc;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .irq   (irq[g]),
      .rise  (rise[g])
    );
  end

  // Scanning from high to low lets the lowest eligible index overwrite last.
  always_comb begin
    elig   = pending & ien;
    take   = (state == ST_IDLE) && (|elig);
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) winner = INTR_ID_W'(i);
    end
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = take && (winner == INTR_ID_W'(i));
    end
    vec_calc = PC_W'(32'(VEC_BASE) + 32'(winner) * VEC_STRIDE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      ien            <= '0;
      pending        <= '0;
      overrun        <= '0;
      irq_id         <= '0;
      vector         <= VEC_BASE;
      s_interruption <= 1'b0;
      in_service     <= 1'b0;
    end else begin
      if (ien_we) ien <= ien_in;

      // A new edge wins over the acceptance clear of the same line.
      pending <= (pending & ~clr) | rise;

      // A new overrun wins over ovr_clr in the same cycle.
      if (ovr_clr) overrun <= rise & pending & ~clr;
      else         overrun <= overrun | (rise & pending & ~clr);

      // Outputs are registered alongside the state so s_interruption is
      // exactly "state == ST_ENTER" with no path from irq.
      case (state)
        ST_IDLE: begin
          if (take) begin
            state          <= ST_ENTER;
            irq_id         <= winner;
            vector         <= vec_calc;
            s_interruption <= 1'b1;
            in_service     <= 1'b1;
          end
        end
        ST_ENTER: begin
          state          <= ST_SERVICE;
          s_interruption <= 1'b0;
          in_service     <= 1'b1;
        end
        ST_SERVICE: begin
          if (s_finish_interr) begin
            state      <= ST_IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          s_interruption <= 1'b0;
          in_service     <= 1'b0;
        end
      endcase
    end
  end

endmodule
